// File: rtl/wvb_rd_arbiter.sv
// Round-robin owner of the shared waveform-buffer read controller and direct-readout DPRAM.
// Grant registered one edge after a non-empty flag; holds the channel across DPRAM continuations until software is done.
module wvb_rd_arbiter #(
    parameter int P_N_CHAN    = 24,
    parameter int P_IDX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   dpram_mode_cfg,
    input  logic [P_N_CHAN-1:0]    wvb_not_empty,
    output logic [P_IDX_WIDTH-1:0] wvb_sel,
    output logic                   rd_ctrl_req,
    output logic [7:0]             rd_ctrl_idx,
    output logic                   rd_ctrl_dpram_mode,
    input  logic                   rd_ctrl_ack,
    input  logic                   rd_ctrl_more,
    input  logic [15:0]            rd_ctrl_dpram_len,
    output logic                   dpram_ready,
    output logic [15:0]            dpram_len,
    input  logic                   dpram_done,
    output logic                   busy,
    output logic [15:0]            evt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_ACK_LOW = 2'd2,
        S_SW_WAIT = 2'd3
    } state_t;

    state_t                 state;
    logic [P_IDX_WIDTH-1:0] ptr;
    logic [P_IDX_WIDTH-1:0] grant;
    logic                   more;
    logic [2*P_N_CHAN-1:0]  rot;
    int                     sum;

    // rot[k] is channel (ptr+k) mod N; scanning far-to-near leaves the nearest set channel after ptr.
    always_comb begin
        rot   = {wvb_not_empty, wvb_not_empty} >> ptr;
        grant = ptr;
        sum   = 0;
        for (int i = P_N_CHAN; i >= 1; i--) begin
            if (rot[i]) begin
                sum = int'(ptr) + i;
                if (sum >= P_N_CHAN)
                    sum = sum - P_N_CHAN;
                grant = P_IDX_WIDTH'(sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            ptr                <= P_IDX_WIDTH'(P_N_CHAN - 1);
            more               <= 1'b0;
            wvb_sel            <= '0;
            rd_ctrl_req        <= 1'b0;
            rd_ctrl_idx        <= 8'd0;
            rd_ctrl_dpram_mode <= 1'b0;
            dpram_ready        <= 1'b0;
            dpram_len          <= 16'd0;
            busy               <= 1'b0;
            evt_cnt            <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && |wvb_not_empty) begin
                        wvb_sel            <= grant;
                        rd_ctrl_idx        <= 8'(grant);
                        rd_ctrl_dpram_mode <= dpram_mode_cfg;
                        rd_ctrl_req        <= 1'b1;
                        busy               <= 1'b1;
                        state              <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_ctrl_ack) begin
                        dpram_len   <= rd_ctrl_dpram_len;
                        more        <= rd_ctrl_more;
                        rd_ctrl_req <= 1'b0;
                        state       <= S_ACK_LOW;
                    end
                end
                S_ACK_LOW: begin
                    if (!rd_ctrl_ack) begin
                        dpram_ready <= 1'b1;
                        state       <= S_SW_WAIT;
                    end
                end
                S_SW_WAIT: begin
                    if (dpram_done) begin
                        dpram_ready <= 1'b0;
                        dpram_len   <= 16'd0;
                        if (more) begin
                            // Continuation keeps the committed channel and mode; no re-arbitration.
                            rd_ctrl_req <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            ptr     <= wvb_sel;
                            evt_cnt <= evt_cnt + 16'd1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    rd_ctrl_req <= 1'b0;
                    dpram_ready <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Bench for wvb_rd_arbiter: acts as read controller and software, checks grants against a round-robin model.
module tb_wvb_rd_arbiter;
    localparam int N  = 24;
    localparam int W  = 8;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          dpram_mode_cfg;
    logic [N-1:0]  wvb_not_empty;
    logic [W-1:0]  wvb_sel;
    logic          rd_ctrl_req;
    logic [7:0]    rd_ctrl_idx;
    logic          rd_ctrl_dpram_mode;
    logic          rd_ctrl_ack;
    logic          rd_ctrl_more;
    logic [15:0]   rd_ctrl_dpram_len;
    logic          dpram_ready;
    logic [15:0]   dpram_len;
    logic          dpram_done;
    logic          busy;
    logic [15:0]   evt_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    int            m_ptr = N - 1;
    logic [15:0]   m_evt = 16'd0;

    wvb_rd_arbiter #(.P_N_CHAN(N), .P_IDX_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .dpram_mode_cfg(dpram_mode_cfg),
        .wvb_not_empty(wvb_not_empty), .wvb_sel(wvb_sel), .rd_ctrl_req(rd_ctrl_req),
        .rd_ctrl_idx(rd_ctrl_idx), .rd_ctrl_dpram_mode(rd_ctrl_dpram_mode),
        .rd_ctrl_ack(rd_ctrl_ack), .rd_ctrl_more(rd_ctrl_more),
        .rd_ctrl_dpram_len(rd_ctrl_dpram_len), .dpram_ready(dpram_ready),
        .dpram_len(dpram_len), .dpram_done(dpram_done), .busy(busy), .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Next channel after p (mod N) whose flag is set.
    function automatic int rr_pick(input logic [N-1:0] f, input int p);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (p + k) % N;
            if (f[c[CW-1:0]])
                return c;
        end
        return -1;
    endfunction

    task automatic run_event(input logic [N-1:0] flags, input logic mode, input int n_cont,
                             input logic drop_en, input logic [15:0] l0, input logic [15:0] l1,
                             output int got_idx);
        int          g;
        logic [15:0] len;
        g = rr_pick(flags, m_ptr);
        wvb_not_empty  = flags;
        dpram_mode_cfg = mode;
        en             = 1'b1;
        @(negedge clk);
        got_idx = int'(rd_ctrl_idx);
        chk("grant_req", rd_ctrl_req, 1);
        chk("grant_idx", rd_ctrl_idx, g);
        chk("grant_sel", wvb_sel, g);
        chk("grant_mode", rd_ctrl_dpram_mode, mode);
        chk("grant_busy", busy, 1);
        wvb_not_empty  = N'($urandom);
        dpram_mode_cfg = ~mode;
        for (int d = 0; d <= n_cont; d++) begin
            len = (d == 0) ? l0 : (d == 1) ? l1 : 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                dpram_done = 1'b1;
                @(negedge clk);
                dpram_done = 1'b0;
                chk("stray_req", rd_ctrl_req, 1);
                chk("stray_req_evt", evt_cnt, m_evt);
            end
            rd_ctrl_ack       = 1'b1;
            rd_ctrl_dpram_len = len;
            rd_ctrl_more      = (d < n_cont);
            @(negedge clk);
            chk("ack_req_drop", rd_ctrl_req, 0);
            chk("ack_not_ready", dpram_ready, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                dpram_done = 1'b1;
                @(negedge clk);
                dpram_done = 1'b0;
                chk("stray_ack_ready", dpram_ready, 0);
                chk("stray_ack_req", rd_ctrl_req, 0);
            end
            rd_ctrl_ack       = 1'b0;
            rd_ctrl_dpram_len = 16'($urandom);
            rd_ctrl_more      = 1'($urandom);
            dpram_done        = 1'($urandom_range(0, 1));
            @(negedge clk);
            dpram_done = 1'b0;
            chk("ready", dpram_ready, 1);
            chk("len", dpram_len, len);
            chk("hold_idx", rd_ctrl_idx, g);
            if (drop_en && d == 0)
                en = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("ready_hold", dpram_ready, 1);
            dpram_done = 1'b1;
            @(negedge clk);
            dpram_done = 1'b0;
            chk("done_ready", dpram_ready, 0);
            chk("done_len", dpram_len, 0);
            if (d < n_cont) begin
                chk("cont_req", rd_ctrl_req, 1);
                chk("cont_idx", rd_ctrl_idx, g);
                chk("cont_mode", rd_ctrl_dpram_mode, mode);
                chk("cont_evt", evt_cnt, m_evt);
            end
        end
        m_ptr = g;
        m_evt = m_evt + 16'd1;
        chk("end_req", rd_ctrl_req, 0);
        chk("end_busy", busy, 0);
        chk("evt_cnt", evt_cnt, m_evt);
        if (drop_en) begin
            wvb_not_empty = '1;
            repeat (2) @(negedge clk);
            chk("en_off_req", rd_ctrl_req, 0);
            chk("en_off_busy", busy, 0);
        end
        en = 1'b0;
    endtask

    initial begin
        int           gi;
        logic [N-1:0] flags;
        rst = 1'b1; en = 1'b0; dpram_mode_cfg = 1'b0; wvb_not_empty = '0;
        rd_ctrl_ack = 1'b0; rd_ctrl_more = 1'b0; rd_ctrl_dpram_len = 16'd0; dpram_done = 1'b0;
        #1;
        chk("rst_req", rd_ctrl_req, 0);
        chk("rst_ready", dpram_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt", evt_cnt, 0);
        chk("rst_sel", wvb_sel, 0);
        chk("rst_len", dpram_len, 0);
        @(negedge clk);
        rst = 1'b0;

        // single channel pair: 0 then 2
        run_event(24'h000005, 1'b0, 0, 1'b0, 16'h0040, 16'h0, gi);
        run_event(24'h000005, 1'b0, 0, 1'b0, 16'h0011, 16'h0, gi);
        chk("single_second", gi, 2);

        // continuation, then continuation with en dropped
        run_event(24'h0F00F0, 1'b1, 1, 1'b0, 16'd2048, 16'd100, gi);
        run_event(24'h0F00F0, 1'b1, 1, 1'b1, 16'h1234, 16'h0042, gi);

        // idle: stray done, and en with no flags
        wvb_not_empty = 24'h000001; dpram_done = 1'b1;
        @(negedge clk);
        dpram_done = 1'b0; en = 1'b1; wvb_not_empty = '0;
        @(negedge clk);
        chk("idle_stray_req", rd_ctrl_req, 0);
        chk("idle_stray_busy", busy, 0);
        chk("idle_stray_evt", evt_cnt, m_evt);
        chk("idle_stray_ready", dpram_ready, 0);

        // asynchronous reset while requesting
        wvb_not_empty = 24'h800001;
        @(negedge clk);
        chk("pre_rst_req", rd_ctrl_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", rd_ctrl_req, 0);
        chk("arst_ready", dpram_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_evt", evt_cnt, 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        m_ptr = N - 1;
        m_evt = 16'd0;

        // fairness with every flag set
        for (int k = 0; k < N + 2; k++) begin
            run_event('1, 1'b0, 0, 1'b0, 16'($urandom), 16'($urandom), gi);
            chk("fair_order", gi, k % N);
        end

        // randomized events
        for (int k = 0; k < 40; k++) begin
            flags = ($urandom_range(0, 2) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
            if (flags == '0)
                flags[0] = 1'b1;
            run_event(flags, 1'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                      16'($urandom), 16'($urandom), gi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wvb_rd_arbiter.md
Name: wvb_rd_arbiter

Overview:
- Round-robin scheduler that shares the single waveform-buffer read controller (format 0) and its direct-readout DPRAM between N channel waveform buffers.
- Selects a non-empty channel, drives the read controller's req/idx/dpram_mode handshake and steers the channel mux.
- Captures the written length and hands the filled DPRAM to software via a ready/done handshake.
- Handles multi-DPRAM continuation (rd_ctrl_more) before granting another channel.

Parameters:
- P_N_CHAN, 24, number of waveform buffer channels (1..256).
- P_IDX_WIDTH, 8, width of channel index; must satisfy 2^P_IDX_WIDTH >= P_N_CHAN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  arbitration enable
- dpram_mode_cfg  in  1  0: truncate event at one DPRAM; 1: extend across DPRAMs
- wvb_not_empty  in  P_N_CHAN  per-channel "event available" flags
- wvb_sel  out  P_IDX_WIDTH  channel mux select for wvb_data/hdr_data/rdreq/rddone
- rd_ctrl_req  out  1  request to read controller
- rd_ctrl_idx  out  8  channel number to read controller (zero-extended wvb_sel)
- rd_ctrl_dpram_mode  out  1  latched DPRAM mode to read controller
- rd_ctrl_ack  in  1  read controller ack, held until req drops
- rd_ctrl_more  in  1  more data pending after this DPRAM; valid while ack=1
- rd_ctrl_dpram_len  in  16  16-bit word count written; valid while ack=1
- dpram_ready  out  1  DPRAM filled, owned by software
- dpram_len  out  16  captured word count; valid while dpram_ready=1
- dpram_done  in  1  software single-cycle pulse: DPRAM read complete
- busy  out  1  high in every state except S_IDLE
- evt_cnt  out  16  completed-event counter, wraps at 0xFFFF->0

Behaviour:
- Reset (async, immediate, no clock edge needed): all outputs 0; fsm=S_IDLE; last-grant pointer = P_N_CHAN-1, so channel 0 has first priority; latched more=0.
- Round-robin grant: first set bit of wvb_not_empty scanning from pointer+1 upward, wrapping at P_N_CHAN-1 -> 0. The pointer channel itself is lowest priority. Grant is computed combinationally and registered on the S_IDLE exit edge.
- S_IDLE: busy=0.
  - If en && |wvb_not_empty: latch grant into wvb_sel/rd_ctrl_idx, latch dpram_mode_cfg into rd_ctrl_dpram_mode, set rd_ctrl_req=1, go S_REQ.
  - Latency: req is asserted on the first edge after not_empty is seen.
- S_REQ: hold req=1 until rd_ctrl_ack=1.
  - On the ack cycle: capture dpram_len<=rd_ctrl_dpram_len and more<=rd_ctrl_more, set req<=0, go S_ACK_LOW.
- S_ACK_LOW: wait for rd_ctrl_ack=0, then dpram_ready<=1 and go S_SW_WAIT.
- S_SW_WAIT: hold dpram_ready and dpram_len. On dpram_done:
  - dpram_ready<=0, dpram_len<=0.
  - If more=1: req<=1 with the same idx and mode, no re-arbitration, go S_REQ.
  - If more=0: pointer<=wvb_sel, evt_cnt<=evt_cnt+1, go S_IDLE.
- dpram_done is ignored in every state other than S_SW_WAIT. A done arriving on the same edge that dpram_ready rises is ignored.
- en=0 mid-event:
  - The current event completes, including all continuations.
  - No new grant is made while en=0.
- wvb_not_empty changes after a grant do not affect the committed channel.
- wvb_sel, rd_ctrl_idx and rd_ctrl_dpram_mode are constant from grant until return to S_IDLE.
- Idle outputs: wvb_sel/rd_ctrl_idx keep their last value in S_IDLE; req=0.
- Width: rd_ctrl_idx = {(8-P_IDX_WIDTH) zeros, wvb_sel}. Pointer wrap uses a compare against P_N_CHAN-1, not a power-of-two rollover.
- Illegal fsm encodings: go to S_IDLE, req=0, dpram_ready=0.

Test Plan:
- Single channel: after reset, wvb_not_empty=0x000005, en=1. Required: req rises 1 cycle later with idx=0. Model acks with len=0x0040, more=0. Required: dpram_ready=1, dpram_len=0x0040. After done: idx=2 is granted, then evt_cnt=2.
- Fairness: all 24 flags held high, auto done. Required: grants in order 0,1,...,23,0,1 with no channel repeated before the wrap.
- Continuation: dpram_mode_cfg=1. First ack has more=1, len=2048. Required: dpram_len=2048. After done, req re-asserts with the same idx and no other channel granted. Second ack has more=0, len=100. Required: dpram_len=100, evt_cnt increments by 1 only.
- en dropped while in S_SW_WAIT with more=1. Required: continuation still runs. After the final done: busy=0 and req stays 0 although flags remain set.
- Async reset asserted mid-S_REQ between clock edges. Required: req, dpram_ready, busy, evt_cnt read 0 before the next edge. After release, channel 0 has priority.
- Spurious dpram_done pulses in S_IDLE, S_REQ and S_ACK_LOW. Required: no state change, evt_cnt unchanged, dpram_ready not cleared early.
